// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with one shared hex decoder,
// dead time between digits, leading-zero blanking and frame-aligned updates.

module hex2seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // seg[0] = top (a) .. seg[6] = middle (g), active-high
    always_comb begin
        seg = 7'h00;
        unique case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule

module seg7_scan_ctrl #(
    parameter int DIV  = 1024,
    parameter int DEAD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        blank_lz,
    output logic [6:0]  segments,
    output logic [3:0]  digit_en,
    output logic        frame_done
);

    localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_M1 = CW'(DEAD - 1);

    typedef enum logic {
        SHOW,
        BLANK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          commit_q, commit_d;
    logic          frame_q, frame_d;

    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    logic          blank_dig;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BLANK;
            idx_q     <= 2'd3;
            cnt_q     <= '0;
            disp_q    <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            commit_q  <= commit_d;
            frame_q   <= frame_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        commit_d  = 1'b0;
        frame_d   = 1'b0;

        unique case (state_q)
            SHOW: begin
                if (cnt_q == DIV_M1) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == DEAD_M1) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        frame_d = 1'b1;
                        if (pending_q) begin
                            disp_d   = shadow_q;
                            commit_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Requester sees ready again only after the frame pulse of the commit
        if (commit_q) begin
            pending_d = 1'b0;
        end

        if (wr_valid && !pending_q) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        nib       = disp_q[3:0];
        blank_dig = 1'b0;
        unique case (idx_q)
            2'd0: begin
                nib       = disp_q[3:0];
                blank_dig = 1'b0;
            end
            2'd1: begin
                nib       = disp_q[7:4];
                blank_dig = (disp_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib       = disp_q[11:8];
                blank_dig = (disp_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib       = disp_q[15:12];
                blank_dig = (disp_q[15:12] == 4'h0);
            end
        endcase
    end

    hex2seg7 u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        segments = 7'h00;
        digit_en = 4'b0000;
        if (state_q == SHOW) begin
            digit_en = 4'b0001 << idx_q;
            if (!(blank_lz && blank_dig)) begin
                segments = dec_seg;
            end
        end
    end

    assign wr_ready   = !pending_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: timing-formula reference model, decode/blanking
// vector table, directed reset/write sequences and random writes.

module tb_seg7_scan_ctrl;

    localparam int DIV   = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = DIV + DEAD;
    localparam int FRAME = 4 * SLOT;

    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        wr_ready;
    logic        blank_lz = 1'b0;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    int unsigned t;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend, m_clr;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .blank_lz   (blank_lz),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    function automatic void model_reset();
        t        = 0;
        m_disp   = 16'h0000;
        m_shadow = 16'h0000;
        m_pend   = 1'b0;
        m_clr    = 1'b0;
    endfunction

    // Expected outputs from elapsed time since reset release alone
    function automatic void model_out(input bit blz, output logic [6:0] s,
                                      output logic [3:0] en, output logic fd,
                                      output logic rdy);
        int u, w, d, p;
        logic [15:0] up;
        s   = 7'h00;
        en  = 4'b0000;
        fd  = 1'b0;
        rdy = !m_pend;
        if (t >= DEAD) begin
            u  = int'(t) - DEAD;
            w  = u % FRAME;
            d  = w / SLOT;
            p  = w % SLOT;
            fd = (w == 0);
            if (p < DIV) begin
                en = 4'(1 << d);
                up = m_disp >> (4 * d);
                if (!(blz && d > 0 && up == 16'h0000))
                    s = SEG[up[3:0]];
            end
        end
    endfunction

    function automatic void model_step(input bit v, input logic [15:0] d);
        bit old, nxt_start;
        old = m_pend;
        if (m_clr) begin
            m_pend = 1'b0;
            m_clr  = 1'b0;
        end
        if (v && !old) begin
            m_shadow = d;
            m_pend   = 1'b1;
        end
        nxt_start = (t + 1 >= DEAD) && (((t + 1 - DEAD) % FRAME) == 0);
        if (nxt_start && old) begin
            m_disp = m_shadow;
            m_clr  = 1'b1;
        end
        t++;
    endfunction

    // Called at a falling edge; returns at the next falling edge
    task automatic run_cycle(input bit v, input logic [15:0] d, input bit blz,
                             output bit acc);
        logic [6:0] es;
        logic [3:0] ee;
        logic       ef, er;
        wr_valid = v;
        wr_data  = d;
        blank_lz = blz;
        #1;
        model_out(blz, es, ee, ef, er);
        check("outs{seg,en,fd,rdy}", {19'd0, segments, digit_en, frame_done,
              wr_ready}, {19'd0, es, ee, ef, er});
        acc = v && er;
        model_step(v, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        #1;
        check("reset_outs", {19'd0, segments, digit_en, frame_done, wr_ready},
              {19'd0, 7'h00, 4'b0000, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] val;
        bit          blz;
        int          dig;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs [20];

    initial begin
        bit acc;
        bit ok;
        bit blz;
        logic [15:0] rd;

        vecs[0]  = '{16'h0005, 1'b1, 0, 7'b1101101};
        vecs[1]  = '{16'h0005, 1'b1, 1, 7'b0000000};
        vecs[2]  = '{16'h0005, 1'b1, 3, 7'b0000000};
        vecs[3]  = '{16'h0005, 1'b0, 1, 7'b0111111};
        vecs[4]  = '{16'h0005, 1'b0, 3, 7'b0111111};
        vecs[5]  = '{16'h0000, 1'b1, 0, 7'b0111111};
        vecs[6]  = '{16'h0000, 1'b1, 2, 7'b0000000};
        vecs[7]  = '{16'h0800, 1'b1, 3, 7'b0000000};
        vecs[8]  = '{16'h0800, 1'b1, 2, 7'b1111111};
        vecs[9]  = '{16'h0800, 1'b1, 1, 7'b0111111};
        vecs[10] = '{16'h0800, 1'b1, 0, 7'b0111111};
        vecs[11] = '{16'h0800, 1'b0, 3, 7'b0111111};
        vecs[12] = '{16'hC0DE, 1'b1, 3, 7'b0111001};
        vecs[13] = '{16'hC0DE, 1'b1, 2, 7'b0111111};
        vecs[14] = '{16'hC0DE, 1'b1, 1, 7'b1011110};
        vecs[15] = '{16'hC0DE, 1'b1, 0, 7'b1111001};
        vecs[16] = '{16'h9876, 1'b0, 0, 7'b1111101};
        vecs[17] = '{16'h9876, 1'b0, 1, 7'b0000111};
        vecs[18] = '{16'h00B0, 1'b1, 1, 7'b1111100};
        vecs[19] = '{16'h00B0, 1'b1, 2, 7'b0000000};

        t = 0;
        @(negedge clk);
        do_reset();

        // Power-up scan: two dark cycles, first boundary, digit 0 lit
        for (int i = 0; i < 9; i++) begin
            logic [3:0] een;
            een = (i >= 2 && i <= 5) ? 4'b0001 : (i == 8) ? 4'b0010 : 4'b0000;
            #1;
            check("pwrup_en", {28'd0, digit_en}, {28'd0, een});
            check("pwrup_fd", {31'd0, frame_done}, {31'd0, (i == 2)});
            if (i >= 2 && i <= 5)
                check("pwrup_seg", {25'd0, segments}, {25'd0, 7'b0111111});
            run_cycle(1'b0, 16'h0000, 1'b0, acc);
        end

        // Write just before the first boundary commits at that boundary
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i >= 1 && i <= 3)
                check("w1234_rdy", {31'd0, wr_ready}, {31'd0, (i == 3)});
            if (i == 2)
                check("w1234_d0", {25'd0, segments}, {25'd0, 7'b1100110});
            if (i == 8)
                check("w1234_d1", {25'd0, segments}, {25'd0, 7'b1001111});
            run_cycle(i == 0, 16'h1234, 1'b0, acc);
        end

        // Held valid: second value waits, first shows a full frame
        do_reset();
        rd = 16'hA5C7;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (i == 20)
                check("b2b_d3_A", {25'd0, segments}, {25'd0, 7'b1110111});
            if (i == 26)
                check("b2b_d0_F", {25'd0, segments}, {25'd0, 7'b1110001});
            run_cycle(1'b1, rd, 1'b0, acc);
            if (acc) rd = 16'h0E0F;
        end

        // Decode and leading-zero blanking vectors
        foreach (vecs[k]) begin
            ok = 1'b0;
            for (int n = 0; n < 200 && !ok; n++) begin
                run_cycle(1'b1, vecs[k].val, vecs[k].blz, acc);
                ok = acc;
            end
            for (int n = 0; n < 200 && ok && m_disp != vecs[k].val; n++)
                run_cycle(1'b0, 16'h0000, vecs[k].blz, acc);
            ok = ok && (m_disp == vecs[k].val);
            for (int n = 0; n < 200 && ok; n++) begin
                logic [6:0] es;
                logic [3:0] ee;
                logic       ef, er;
                blank_lz = vecs[k].blz;
                wr_valid = 1'b0;
                #1;
                model_out(vecs[k].blz, es, ee, ef, er);
                if (ee == 4'(1 << vecs[k].dig)) begin
                    check($sformatf("vec%0d_seg", k), {25'd0, segments},
                          {25'd0, vecs[k].seg});
                    check($sformatf("vec%0d_en", k), {28'd0, digit_en},
                          {28'd0, ee});
                    break;
                end
                run_cycle(1'b0, 16'h0000, vecs[k].blz, acc);
            end
            if (!ok) check($sformatf("vec%0d_timeout", k), 32'd0, 32'd1);
        end

        // Random writes and blanking toggles against the model
        blz = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 64) == 0) blz = 1'($urandom_range(0, 1));
            rd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rd[15:8] = 8'h00;
            run_cycle($urandom_range(0, 9) < 3, rd, blz, acc);
        end

        // Async reset during digit 2 with a write pending
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            logic [6:0] es;
            logic [3:0] ee;
            logic       ef, er;
            model_out(1'b0, es, ee, ef, er);
            ok = m_pend && (ee == 4'b0100);
            if (!ok) run_cycle(1'b1, 16'h7777, 1'b0, acc);
        end
        if (!ok) check("rst_mid_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
        blank_lz = 1'b0;
        #1;
        check("pre_rst_en", {28'd0, digit_en}, {28'd0, 4'b0100});
        check("pre_rst_rdy", {31'd0, wr_ready}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst", {19'd0, segments, digit_en, frame_done, wr_ready},
              {19'd0, 7'h00, 4'b0000, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            #1;
            if (i == 2) begin
                check("post_rst_d0", {25'd0, segments}, {25'd0, 7'b0111111});
                check("post_rst_fd", {31'd0, frame_done}, 32'd1);
            end
            if (i == 20)
                check("post_rst_d3", {25'd0, segments}, {25'd0, 7'b0111111});
            run_cycle(1'b0, 16'h0000, 1'b0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d got=running want=done", t);
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1024, number of clk cycles each digit is lit; legal range 2..65535.
REQ-002 Parameter DEAD, default 4, number of dark cycles between digits (anti-ghosting); legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  requester offers a new 4-digit value on wr_data.
REQ-006 wr_data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 wr_ready  output  1  block can accept wr_data this cycle.
REQ-008 blank_lz  input  1  level; 1 enables leading-zero blanking.
REQ-009 segments  output  7  segment drive for the lit digit, bit0 = seg 1 (top) .. bit6 = seg 7 (middle), active-high.
REQ-010 digit_en  output  4  one-hot, active-high digit select; bit i lights digit i.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The block SHALL instantiate the team's hex2seg7 decoder exactly once and time-share it across the four digits; no other segment encoding is permitted.
REQ-013 Registers: state (SHOW, BLANK), idx[1:0], cnt (wide enough for max(DIV,DEAD)-1), disp[15:0], shadow[15:0], pending.
REQ-014 SHOW: digit_en = one-hot(idx); segments = hex2seg7(disp nibble idx), or 7'b0 when that digit is blanked per REQ-019.
REQ-015 SHOW: cnt increments each cycle; at cnt = DIV-1 the next state is BLANK with cnt = 0.
REQ-016 BLANK: digit_en = 4'b0000 and segments = 7'b0; cnt increments; at cnt = DEAD-1 the next state is SHOW, cnt = 0, idx = idx+1 mod 4.
REQ-017 Frame boundary = BLANK-to-SHOW transition with idx wrapping 3 to 0; in that same cycle frame_done SHALL be 1, and if pending = 1 then disp <= shadow and pending <= 0.
REQ-018 wr_ready SHALL equal !pending; when wr_valid && wr_ready, shadow <= wr_data and pending <= 1; wr_data is ignored when wr_ready = 0.
REQ-019 Digit i (i = 1..3) is blanked iff blank_lz = 1 and disp[15:4i] = 0; digit 0 is never blanked; blanked digits keep digit_en asserted.
REQ-020 disp SHALL change only at frame boundaries; a frame never mixes two values.
REQ-021 Frame period SHALL be exactly 4*(DIV+DEAD) cycles; outputs are combinational from registered state only (wr_data and wr_valid never reach segments or digit_en combinationally).
REQ-022 Accept and commit cannot coincide, because wr_ready = 0 whenever pending = 1; a write accepted in the cycle before a boundary SHALL commit at that boundary.

Reset
REQ-023 While reset = 1: state = BLANK, idx = 3, cnt = 0, disp = 0, shadow = 0, pending = 0; outputs segments = 0, digit_en = 0, frame_done = 0, wr_ready = 1, taking effect immediately without waiting for a clock edge.
REQ-024 Reset asserted mid-frame or with a pending write SHALL discard the pending value; the first frame boundary occurs DEAD cycles after reset release.

Verification (DIV=4, DEAD=2)
REQ-025 Reset release -> cycles 0-1 digit_en=0000, wr_ready=1; cycle 2 frame_done=1, digit_en=0001, segments=0111111 for 4 cycles, then 0000 for 2 cycles, then 0010.
REQ-026 Write 0x1234 at cycle 0 after reset -> wr_ready=0 at cycles 1-2; from cycle 2, digits 0..3 show 1100110, 1001111, 1011011, 0000110; wr_ready=1 from cycle 3.
REQ-027 Two back-to-back writes 0xA5C7 then 0x0E0F with wr_valid held -> second accepted only in the cycle after the first commits; display shows 0xA5C7 for one full 24-cycle frame before 0x0E0F.
REQ-028 disp=0x0005, blank_lz=1 -> digit 0 segments=1101101, digits 1-3 segments=0000000 with digit_en still asserted; with blank_lz=0, digits 1-3 show 0111111; disp=0x0000 with blank_lz=1 -> digit 0 shows 0111111.
REQ-029 disp=0x0800, blank_lz=1 -> digit 3 blank, digit 2 shows 1111111, digits 1 and 0 show 0111111.
REQ-030 Reset pulsed asynchronously while SHOW idx=2 with pending=1 -> outputs go to 0 before the next edge, wr_ready=1, and after release the first frame shows 0000.
